freq_meter: RTL and testbench

Gated-window frequency meter that measures the rate of an external or divided clock. It counts rising edges of an asynchronous input over a fixed window of `clk` cycles and publishes the count once per window with a one-cycle valid strobe. It sits downstream of the clock-divider outputs and of board-level clock/pulse pins, and is used for bring-up checks and for LED/UART readout of measured rates.

---
 rtl/freq_meter.sv | 192 +++++++++++++++++++
 tb/tb_freq_meter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// Gated-window frequency meter.
// Counts rising edges of an asynchronous input over a window of GATE_CYCLES
// clk cycles and publishes the count with a one-cycle valid strobe. Windows
// run back-to-back while en stays high; the count saturates and flags ovf.
module freq_meter #(
    parameter int GATE_CYCLES = 27_000_000,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             en,
    output logic [CNT_W-1:0] freq_out,
    output logic             freq_valid,
    output logic             ovf,
    output logic             busy
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [1:0]       SETTLE_LAST = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_GATE   = 2'd2
    } state_t;

    // Saturating increment: the count sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                                 input logic             inc);
        if (inc && (value != CNT_MAX)) begin
            return value + CNT_W'(1);
        end else begin
            return value;
        end
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [1:0]       settle_r;
    logic [1:0]       settle_nxt_s;
    logic [GW-1:0]    gate_cnt_r;
    logic [GW-1:0]    gate_nxt_s;
    logic [CNT_W-1:0] edge_cnt_r;
    logic [CNT_W-1:0] edge_nxt_s;
    logic             sat_r;
    logic             sat_nxt_s;
    logic             publish_s;

    logic             s1_r;
    logic             s2_r;
    logic             s3_r;
    logic             rise_s;
    logic [CNT_W-1:0] cnt_inc_s;
    logic             sat_hit_s;

    logic [CNT_W-1:0] freq_out_r;
    logic             freq_valid_r;
    logic             ovf_r;
    logic             busy_r;

    // Two-flop synchronizer plus history flop; runs in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= sig_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign rise_s    = s2_r & ~s3_r;
    assign cnt_inc_s = sat_inc(edge_cnt_r, rise_s);
    assign sat_hit_s = rise_s & (edge_cnt_r == CNT_MAX);

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            settle_r   <= 2'd0;
            gate_cnt_r <= {GW{1'b0}};
            edge_cnt_r <= {CNT_W{1'b0}};
            sat_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            settle_r   <= settle_nxt_s;
            gate_cnt_r <= gate_nxt_s;
            edge_cnt_r <= edge_nxt_s;
            sat_r      <= sat_nxt_s;
        end
    end

    // Next-state logic: settle after enable, then gate windows back-to-back.
    always_comb begin
        state_nxt_s  = state_r;
        settle_nxt_s = settle_r;
        gate_nxt_s   = gate_cnt_r;
        edge_nxt_s   = edge_cnt_r;
        sat_nxt_s    = sat_r;
        publish_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                settle_nxt_s = 2'd0;
                gate_nxt_s   = {GW{1'b0}};
                edge_nxt_s   = {CNT_W{1'b0}};
                sat_nxt_s    = 1'b0;
                if (en) begin
                    state_nxt_s = ST_SETTLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                // Edges are ignored here so stale synchronizer history never counts.
                gate_nxt_s = {GW{1'b0}};
                edge_nxt_s = {CNT_W{1'b0}};
                sat_nxt_s  = 1'b0;
                if (!en) begin
                    state_nxt_s  = ST_IDLE;
                    settle_nxt_s = 2'd0;
                end else if (settle_r == SETTLE_LAST) begin
                    state_nxt_s  = ST_GATE;
                    settle_nxt_s = 2'd0;
                end else begin
                    settle_nxt_s = settle_r + 2'd1;
                end
            end
            ST_GATE: begin
                if (gate_cnt_r == GATE_LAST) begin
                    // Closing cycle: publish even if en just dropped.
                    publish_s  = 1'b1;
                    gate_nxt_s = {GW{1'b0}};
                    edge_nxt_s = {CNT_W{1'b0}};
                    sat_nxt_s  = 1'b0;
                    if (en) begin
                        state_nxt_s = ST_GATE;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else if (!en) begin
                    // Abort: the partial window is discarded silently.
                    state_nxt_s = ST_IDLE;
                    gate_nxt_s  = {GW{1'b0}};
                    edge_nxt_s  = {CNT_W{1'b0}};
                    sat_nxt_s   = 1'b0;
                end else begin
                    gate_nxt_s = gate_cnt_r + GW'(1);
                    edge_nxt_s = cnt_inc_s;
                    sat_nxt_s  = sat_r | sat_hit_s;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                settle_nxt_s = 2'd0;
                gate_nxt_s   = {GW{1'b0}};
                edge_nxt_s   = {CNT_W{1'b0}};
                sat_nxt_s    = 1'b0;
            end
        endcase
    end

    // Result registers: updated only together with the valid strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            freq_out_r   <= {CNT_W{1'b0}};
            ovf_r        <= 1'b0;
            freq_valid_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            freq_valid_r <= publish_s;
            busy_r       <= (state_nxt_s != ST_IDLE);
            if (publish_s) begin
                freq_out_r <= cnt_inc_s;
                ovf_r      <= sat_r | sat_hit_s;
            end else begin
                freq_out_r <= freq_out_r;
                ovf_r      <= ovf_r;
            end
        end
    end

    assign freq_out   = freq_out_r;
    assign freq_valid = freq_valid_r;
    assign ovf        = ovf_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_freq_meter.sv
// Directed testbench for freq_meter: two instances (32-bit and 4-bit count),
// both with a 100-cycle window, sharing clock, reset and the measured signal.
module tb_freq_meter;

    logic        clk;
    logic        rst;
    logic        en;
    logic        en2;
    logic        lvl;
    logic        gen_mode;
    logic        gen_sig;
    logic        sig_in;
    int          per;
    int          ph;

    logic [31:0] fo1;
    logic        fv1;
    logic        ov1;
    logic        bz1;
    logic [3:0]  fo2;
    logic        fv2;
    logic        ov2;
    logic        bz2;

    int n_tests;
    int n_fail;

    assign sig_in = gen_mode ? gen_sig : lvl;

    freq_meter #(.GATE_CYCLES(100), .CNT_W(32)) dut1 (
        .clk(clk), .rst(rst), .sig_in(sig_in), .en(en),
        .freq_out(fo1), .freq_valid(fv1), .ovf(ov1), .busy(bz1)
    );

    freq_meter #(.GATE_CYCLES(100), .CNT_W(4)) dut2 (
        .clk(clk), .rst(rst), .sig_in(sig_in), .en(en2),
        .freq_out(fo2), .freq_valid(fv2), .ovf(ov2), .busy(bz2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Periodic square wave, per clk cycles, high for the first half.
    initial begin
        gen_sig = 1'b0;
        ph = 0;
        forever begin
            @(negedge clk);
            if (ph >= per - 1) ph = 0;
            else ph++;
            gen_sig = (ph < per / 2);
        end
    end

    task automatic wait_valid(input bit sel, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (!ok && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (sel ? (fv2 === 1'b1) : (fv1 === 1'b1)) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        int  cyc;
        bit  got;
        rst = 1'b1; en = 1'b1; en2 = 1'b0;
        gen_mode = 1'b1; per = 4; lvl = 1'b0;
        repeat (12) @(negedge clk);
        n_tests++; if (fo1 !== 32'd0) begin n_fail++; $display("FAIL reset_freq_out: got %0d expected 0", fo1); end
        n_tests++; if (fv1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", fv1); end
        n_tests++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ov1); end
        n_tests++; if (bz1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bz1); end
        // Release with sig_in high: the synchronizer rise lands in SETTLE.
        gen_mode = 1'b0; lvl = 1'b1; rst = 1'b0;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                n_tests++; if (bz1 !== 1'b1) begin n_fail++; $display("FAIL en_to_busy: got %b expected 1", bz1); end
            end
            if (fv1 === 1'b1) got = 1'b1;
        end
        n_tests++; if (!got || cyc != 104) begin n_fail++; $display("FAIL first_result_latency: got %0d expected 104", cyc); end
        n_tests++; if (fo1 !== 32'd0) begin n_fail++; $display("FAIL reset_release_count: got %0d expected 0", fo1); end
    endtask

    task automatic test_static;
        int cyc;
        bit ok;
        for (int phase = 0; phase < 2; phase++) begin
            lvl = (phase == 0) ? 1'b1 : 1'b0;
            for (int w = 0; w < 3; w++) begin
                wait_valid(1'b0, cyc, ok);
                n_tests++; if (!ok || cyc != 100) begin n_fail++; $display("FAIL static_period lvl%0d w%0d: got %0d expected 100", phase == 0, w, cyc); end
                n_tests++; if (fo1 !== 32'd0) begin n_fail++; $display("FAIL static_count lvl%0d w%0d: got %0d expected 0", phase == 0, w, fo1); end
            end
        end
    endtask

    task automatic test_basic;
        int cyc;
        bit ok;
        gen_mode = 1'b1; per = 10;
        wait_valid(1'b0, cyc, ok);
        for (int w = 0; w < 3; w++) begin
            wait_valid(1'b0, cyc, ok);
            n_tests++; if (!ok || cyc != 100) begin n_fail++; $display("FAIL basic_period w%0d: got %0d expected 100", w, cyc); end
            n_tests++; if (fo1 !== 32'd10) begin n_fail++; $display("FAIL basic_count w%0d: got %0d expected 10", w, fo1); end
            n_tests++; if (ov1 !== 1'b0) begin n_fail++; $display("FAIL basic_ovf w%0d: got %b expected 0", w, ov1); end
        end
    endtask

    task automatic test_abort;
        int cyc;
        bit ok;
        bit saw;
        // Currently in the valid cycle (gate_cnt 0); move to gate_cnt 50.
        repeat (50) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        n_tests++; if (bz1 !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", bz1); end
        saw = 1'b0;
        repeat (150) begin
            @(negedge clk);
            if (fv1 === 1'b1) saw = 1'b1;
        end
        n_tests++; if (saw !== 1'b0) begin n_fail++; $display("FAIL abort_no_valid: got %b expected 0", saw); end
        n_tests++; if (fo1 !== 32'd10) begin n_fail++; $display("FAIL abort_hold: got %0d expected 10", fo1); end
        en = 1'b1;
        wait_valid(1'b0, cyc, ok);
        n_tests++; if (!ok || cyc != 104) begin n_fail++; $display("FAIL reenable_latency: got %0d expected 104", cyc); end
        n_tests++; if (fo1 !== 32'd10) begin n_fail++; $display("FAIL reenable_count: got %0d expected 10", fo1); end
    endtask

    task automatic test_en_close;
        // Drop en exactly on the closing cycle: result still publishes.
        repeat (99) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        n_tests++; if (fv1 !== 1'b1) begin n_fail++; $display("FAIL en_close_valid: got %b expected 1", fv1); end
        n_tests++; if (fo1 !== 32'd10) begin n_fail++; $display("FAIL en_close_count: got %0d expected 10", fo1); end
        n_tests++; if (bz1 !== 1'b0) begin n_fail++; $display("FAIL en_close_busy: got %b expected 0", bz1); end
    endtask

    task automatic test_saturation;
        int cyc;
        bit ok;
        per = 4; en2 = 1'b1;
        wait_valid(1'b1, cyc, ok);
        n_tests++; if (!ok || cyc != 104) begin n_fail++; $display("FAIL sat_latency: got %0d expected 104", cyc); end
        n_tests++; if (fo2 !== 4'd15) begin n_fail++; $display("FAIL sat_count: got %0d expected 15", fo2); end
        n_tests++; if (ov2 !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b expected 1", ov2); end
        per = 10;
        wait_valid(1'b1, cyc, ok);
        wait_valid(1'b1, cyc, ok);
        n_tests++; if (!ok || cyc != 100) begin n_fail++; $display("FAIL unsat_period: got %0d expected 100", cyc); end
        n_tests++; if (fo2 !== 4'd10) begin n_fail++; $display("FAIL unsat_count: got %0d expected 10", fo2); end
        n_tests++; if (ov2 !== 1'b0) begin n_fail++; $display("FAIL unsat_ovf: got %b expected 0", ov2); end
        en2 = 1'b0;
    endtask

    task automatic test_mid_reset_boundary;
        int cyc;
        bit ok;
        int nv;
        int vn [3];
        int vf [3];
        en = 1'b1;
        wait_valid(1'b0, cyc, ok);
        n_tests++; if (fo1 !== 32'd10) begin n_fail++; $display("FAIL pre_reset_count: got %0d expected 10", fo1); end
        repeat (60) @(negedge clk);
        rst = 1'b1; gen_mode = 1'b0; lvl = 1'b0;
        #1;
        n_tests++; if (fo1 !== 32'd0) begin n_fail++; $display("FAIL midrst_freq_out: got %0d expected 0", fo1); end
        n_tests++; if (bz1 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bz1); end
        n_tests++; if (fv1 !== 1'b0 || ov1 !== 1'b0) begin n_fail++; $display("FAIL midrst_valid_ovf: got %b%b expected 00", fv1, ov1); end
        @(negedge clk);
        rst = 1'b0;
        nv = 0;
        for (int n = 1; n <= 310; n++) begin
            @(negedge clk);
            // Rise at n=101 is detected on closing cycle 103; rise at n=202
            // is detected on valid cycle 204 and belongs to the third window.
            if (n == 101) lvl = 1'b1;
            if (n == 150) lvl = 1'b0;
            if (n == 202) lvl = 1'b1;
            if (fv1 === 1'b1 && nv < 3) begin
                vn[nv] = n;
                vf[nv] = int'(fo1);
                nv++;
            end
        end
        n_tests++; if (nv != 3) begin n_fail++; $display("FAIL boundary_valid_count: got %0d expected 3", nv); end
        for (int k = 0; k < nv; k++) begin
            n_tests++; if (vn[k] != 104 + 100 * k) begin n_fail++; $display("FAIL boundary_valid_time w%0d: got %0d expected %0d", k, vn[k], 104 + 100 * k); end
            n_tests++; if (vf[k] != ((k == 1) ? 0 : 1)) begin n_fail++; $display("FAIL boundary_count w%0d: got %0d expected %0d", k, vf[k], (k == 1) ? 0 : 1); end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; en = 1'b0; en2 = 1'b0;
        lvl = 1'b0; gen_mode = 1'b0; per = 10;
        test_reset();
        test_static();
        test_basic();
        test_abort();
        test_en_close();
        test_saturation();
        test_mid_reset_boundary();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
